// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB3 slave protocol engine.
//   - apb_state_t   : protocol FSM encoding (IDLE/SETUP/ACCESS/RESP)
//   - RESP_OKAY/RESP_SLVERR : PSLVERR response codes
//   - APB_ADDR_W/APB_DATA_W : default bus widths
// -----------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

endpackage : apb_pkg

// File: rtl/apb_wait_timer.sv
// -----------------------------------------------------------------------------
// apb_wait_timer
// Saturating ACCESS-phase cycle counter.
// Ports:
//   PCLK, PRESETn : clock, asynchronous active-low reset
//   clr           : synchronous clear to 0 (wins over en)
//   en            : count one cycle (stops at all-ones)
//   wait_cfg      : minimum number of counted cycles before completion
//   min_done      : cnt >= wait_cfg
//   tmo           : cnt == TIMEOUT-1
// -----------------------------------------------------------------------------
module apb_wait_timer #(
    parameter int WAIT_W  = 4,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              clr,
    input  logic              en,
    input  logic [WAIT_W-1:0] wait_cfg,
    output logic              min_done,
    output logic              tmo
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (en && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // CNT_W is never narrower than WAIT_W, so zero-extending wait_cfg is lossless.
    assign min_done = (cnt_reg >= CNT_W'(wait_cfg));
    assign tmo      = (cnt_reg == CNT_W'(TIMEOUT - 1));

endmodule : apb_wait_timer

// File: rtl/apb_slave_ctrl.sv
// -----------------------------------------------------------------------------
// apb_slave_ctrl
// APB3 slave protocol engine bridging the APB bus to a req/ack backend.
// Ports:
//   PCLK, PRESETn          : APB clock, asynchronous active-low reset
//   PSEL, PENABLE, PWRITE  : APB control
//   PADDR, PWDATA          : APB address / write data
//   PREADY, PSLVERR, PRDATA: APB response (one-cycle PREADY in RESP)
//   wait_cfg               : minimum ACCESS cycles before completion
//   bk_req, bk_wr          : backend request level / write flag
//   bk_addr, bk_wdata      : latched address / write data
//   bk_ack, bk_rdata,bk_err: backend single-cycle acknowledge with data/error
//   busy                   : FSM not in IDLE
//   prot_err               : one-cycle pulse when PSEL drops mid-transfer
// All outputs come from registers or state decode; no bus input reaches an
// output combinationally.
// -----------------------------------------------------------------------------
module apb_slave_ctrl
    import apb_pkg::*;
#(
    parameter int                ADDR_W   = APB_ADDR_W,
    parameter int                DATA_W   = APB_DATA_W,
    parameter int                WAIT_W   = 4,
    parameter logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'('h3F),
    parameter int                TIMEOUT  = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] PRDATA,
    input  logic [WAIT_W-1:0] wait_cfg,
    output logic              bk_req,
    output logic              bk_wr,
    output logic [ADDR_W-1:0] bk_addr,
    output logic [DATA_W-1:0] bk_wdata,
    input  logic              bk_ack,
    input  logic [DATA_W-1:0] bk_rdata,
    input  logic              bk_err,
    output logic              busy,
    output logic              prot_err
);

    // The counter must reach both TIMEOUT-1 and every wait_cfg value.
    localparam int CNT_W = (WAIT_W > $clog2(TIMEOUT)) ? WAIT_W : $clog2(TIMEOUT);

    apb_state_t        state_reg,     state_next;
    logic [ADDR_W-1:0] addr_reg,      addr_next;
    logic [DATA_W-1:0] wdata_reg,     wdata_next;
    logic              write_reg,     write_next;
    logic              range_err_reg, range_err_next;
    logic              ack_seen_reg,  ack_seen_next;
    logic [DATA_W-1:0] rdata_cap_reg, rdata_cap_next;
    logic              err_cap_reg,   err_cap_next;
    logic              slverr_reg,    slverr_next;
    logic [DATA_W-1:0] prdata_reg,    prdata_next;
    logic              prot_err_reg,  prot_err_next;

    logic              tmr_clr;
    logic              tmr_en;
    logic              min_done;
    logic              tmo;

    // Combinational helpers for the ACCESS exit decision.
    logic              ack_fire;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_data;

    apb_wait_timer #(
        .WAIT_W  (WAIT_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .wait_cfg (wait_cfg),
        .min_done (min_done),
        .tmo      (tmo)
    );

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        write_next     = write_reg;
        range_err_next = range_err_reg;
        ack_seen_next  = ack_seen_reg;
        rdata_cap_next = rdata_cap_reg;
        err_cap_next   = err_cap_reg;
        slverr_next    = slverr_reg;
        prdata_next    = prdata_reg;
        prot_err_next  = 1'b0;
        tmr_clr        = 1'b0;
        tmr_en         = 1'b0;
        ack_fire       = 1'b0;
        rsp_err        = 1'b0;
        rsp_data       = '0;

        unique case (state_reg)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_next     = SETUP;
                    addr_next      = PADDR;
                    wdata_next     = PWDATA;
                    write_next     = PWRITE;
                    range_err_next = (PADDR > ADDR_MAX);
                    ack_seen_next  = 1'b0;
                    rdata_cap_next = '0;
                    err_cap_next   = 1'b0;
                end
            end

            SETUP: begin
                if (!PSEL) begin
                    state_next    = IDLE;
                    prot_err_next = 1'b1;
                end else if (PENABLE) begin
                    state_next = ACCESS;
                    tmr_clr    = 1'b1;
                end
            end

            ACCESS: begin
                tmr_en = 1'b1;
                // Only the first acknowledge of a transfer is taken.
                ack_fire = bk_ack && !ack_seen_reg;
                if (ack_fire) begin
                    ack_seen_next  = 1'b1;
                    rdata_cap_next = bk_rdata;
                    err_cap_next   = bk_err;
                end

                // An ack arriving in the exit cycle is used directly, since
                // the capture registers only update at this edge.
                rsp_err  = range_err_reg | (ack_fire ? bk_err : err_cap_reg);
                rsp_data = ack_fire ? bk_rdata : rdata_cap_reg;

                if (!PSEL) begin
                    state_next    = IDLE;
                    prot_err_next = 1'b1;
                end else if (tmo) begin
                    state_next  = RESP;
                    slverr_next = RESP_SLVERR;
                    prdata_next = '0;
                end else if ((ack_seen_reg || ack_fire || range_err_reg) && min_done) begin
                    state_next  = RESP;
                    slverr_next = rsp_err ? RESP_SLVERR : RESP_OKAY;
                    prdata_next = (!write_reg && !rsp_err) ? rsp_data : '0;
                end
            end

            RESP: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            write_reg     <= 1'b0;
            range_err_reg <= 1'b0;
            ack_seen_reg  <= 1'b0;
            rdata_cap_reg <= '0;
            err_cap_reg   <= 1'b0;
            slverr_reg    <= 1'b0;
            prdata_reg    <= '0;
            prot_err_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            write_reg     <= write_next;
            range_err_reg <= range_err_next;
            ack_seen_reg  <= ack_seen_next;
            rdata_cap_reg <= rdata_cap_next;
            err_cap_reg   <= err_cap_next;
            slverr_reg    <= slverr_next;
            prdata_reg    <= prdata_next;
            prot_err_reg  <= prot_err_next;
        end
    end

    // bk_req is decoded from registers only, so it falls the cycle after the
    // ack and drops asynchronously with PRESETn.
    assign bk_req   = (state_reg == ACCESS) && !range_err_reg && !ack_seen_reg;
    assign bk_wr    = write_reg;
    assign bk_addr  = addr_reg;
    assign bk_wdata = wdata_reg;

    assign PREADY   = (state_reg == RESP);
    assign PSLVERR  = (state_reg == RESP) && slverr_reg;
    assign PRDATA   = prdata_reg;

    assign busy     = (state_reg != IDLE);
    assign prot_err = prot_err_reg;

endmodule : apb_slave_ctrl

// File: tb/tb_apb_slave_ctrl.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_ctrl
// Directed bench for apb_slave_ctrl. Cycle numbers count edges from the edge
// that launches the setup phase (PSEL driven high just after it).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_slave_ctrl;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int WAIT_W  = 4;
    localparam int TIMEOUT = 16;

    logic              PCLK;
    logic              PRESETn;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic [DATA_W-1:0] PRDATA;
    logic [WAIT_W-1:0] wait_cfg;
    logic              bk_req;
    logic              bk_wr;
    logic [ADDR_W-1:0] bk_addr;
    logic [DATA_W-1:0] bk_wdata;
    logic              bk_ack;
    logic [DATA_W-1:0] bk_rdata;
    logic              bk_err;
    logic              busy;
    logic              prot_err;

    int total = 0;
    int bad   = 0;

    apb_slave_ctrl #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .WAIT_W   (WAIT_W),
        .ADDR_MAX (8'h3F),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .PRDATA   (PRDATA),
        .wait_cfg (wait_cfg),
        .bk_req   (bk_req),
        .bk_wr    (bk_wr),
        .bk_addr  (bk_addr),
        .bk_wdata (bk_wdata),
        .bk_ack   (bk_ack),
        .bk_rdata (bk_rdata),
        .bk_err   (bk_err),
        .busy     (busy),
        .prot_err (prot_err)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // One complete transfer. ack1/ack2 are the cycle numbers in which bk_ack
    // is driven (0 = never); cycle 2 is the first ACCESS cycle.
    task automatic apb_xfer(
        input  string       name,
        input  logic        wr,
        input  logic [7:0]  addr,
        input  logic [31:0] wdata,
        input  int          ack1,
        input  logic [31:0] rd1,
        input  logic        err1,
        input  int          ack2,
        input  logic [31:0] rd2,
        output int          lat,
        output logic        slverr,
        output logic [31:0] rdata,
        output logic        saw_req,
        output logic        a_wr,
        output logic [7:0]  a_addr,
        output logic [31:0] a_wdata
    );
        int cyc;
        tick();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        cyc = 0; lat = 0; slverr = 1'b0; rdata = '0; saw_req = 1'b0;
        a_wr = 1'b0; a_addr = '0; a_wdata = '0;
        tick();
        cyc = 1;
        PENABLE = 1'b1;
        while (lat == 0 && cyc < 40) begin
            tick();
            cyc++;
            bk_ack   = (cyc == ack1) || (cyc == ack2);
            bk_rdata = (cyc == ack1) ? rd1 : ((cyc == ack2) ? rd2 : 32'hDEAD_BEEF);
            bk_err   = (cyc == ack1) ? err1 : 1'b0;
            if (bk_req) saw_req = 1'b1;
            if (cyc == 2) begin
                a_wr = bk_wr; a_addr = bk_addr; a_wdata = bk_wdata;
            end
            if (PREADY) begin
                lat = cyc; slverr = PSLVERR; rdata = PRDATA;
            end
        end
        bk_ack = 1'b0; bk_err = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0;
        if (lat == 0) chk({name, "_bound"}, 32'd0, 32'd1);
        $display("xfer %s wr=%b addr=%h lat=%0d pslverr=%b prdata=%h", name, wr, addr, lat, slverr, rdata);
    endtask

    int          lat;
    logic        slverr, saw_req, a_wr;
    logic [31:0] rdata, a_wdata;
    logic [7:0]  a_addr;
    logic        late_ready;

    initial begin
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; wait_cfg = '0;
        bk_ack = 1'b0; bk_rdata = '0; bk_err = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_pready",  {31'd0, PREADY},  32'd0);
        chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        chk("rst_prdata",  PRDATA,           32'd0);
        chk("rst_bk_req",  {31'd0, bk_req},  32'd0);
        chk("rst_bk_wr",   {31'd0, bk_wr},   32'd0);
        chk("rst_bk_addr", {24'd0, bk_addr}, 32'd0);
        chk("rst_bk_wdata", bk_wdata,        32'd0);
        chk("rst_busy",    {31'd0, busy},    32'd0);
        chk("rst_prot",    {31'd0, prot_err}, 32'd0);
        PRESETn = 1'b1;
        tick();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Basic read, ack in first ACCESS cycle: PREADY at cycle 3
        wait_cfg = 4'd0;
        apb_xfer("rd04", 1'b0, 8'h04, 32'h0, 2, 32'hA5A5_0001, 1'b0, 0, 32'h0,
                 lat, slverr, rdata, saw_req, a_wr, a_addr, a_wdata);
        chk("rd04_lat", lat, 32'd3);
        chk("rd04_err", {31'd0, slverr}, 32'd0);
        chk("rd04_data", rdata, 32'hA5A5_0001);
        chk("rd04_req", {31'd0, saw_req}, 32'd1);
        chk("rd04_addr", {24'd0, a_addr}, 32'h04);
        chk("rd04_wr", {31'd0, a_wr}, 32'd0);
        tick();
        chk("rd04_idle", {31'd0, busy}, 32'd0);
        chk("rd04_hold", PRDATA, 32'hA5A5_0001);

        // Write with wait_cfg=5: completion held until cnt=5 -> cycle 8
        wait_cfg = 4'd5;
        apb_xfer("wr08", 1'b1, 8'h08, 32'h0000_00FF, 2, 32'h0, 1'b0, 0, 32'h0,
                 lat, slverr, rdata, saw_req, a_wr, a_addr, a_wdata);
        chk("wr08_lat", lat, 32'd8);
        chk("wr08_bkwr", {31'd0, a_wr}, 32'd1);
        chk("wr08_wdata", a_wdata, 32'h0000_00FF);
        chk("wr08_err", {31'd0, slverr}, 32'd0);
        chk("wr08_data", rdata, 32'd0);

        // Second ack after the first is ignored; wait_cfg=3 -> cycle 6
        wait_cfg = 4'd3;
        apb_xfer("rd0c", 1'b0, 8'h0C, 32'h0, 2, 32'h1111_1111, 1'b0, 3, 32'h2222_2222,
                 lat, slverr, rdata, saw_req, a_wr, a_addr, a_wdata);
        chk("rd0c_lat", lat, 32'd6);
        chk("rd0c_data", rdata, 32'h1111_1111);

        // Late ack (cycle 4) carrying bk_err: 3+max(2,0)=5, error, PRDATA=0
        wait_cfg = 4'd0;
        apb_xfer("rd10", 1'b0, 8'h10, 32'h0, 4, 32'h3333_3333, 1'b1, 0, 32'h0,
                 lat, slverr, rdata, saw_req, a_wr, a_addr, a_wdata);
        chk("rd10_lat", lat, 32'd5);
        chk("rd10_err", {31'd0, slverr}, 32'd1);
        chk("rd10_data", rdata, 32'd0);

        // Highest valid address
        apb_xfer("rd3f", 1'b0, 8'h3F, 32'h0, 2, 32'h0000_3F3F, 1'b0, 0, 32'h0,
                 lat, slverr, rdata, saw_req, a_wr, a_addr, a_wdata);
        chk("rd3f_lat", lat, 32'd3);
        chk("rd3f_err", {31'd0, slverr}, 32'd0);
        chk("rd3f_data", rdata, 32'h0000_3F3F);

        // Out of range: no backend request, error response at cycle 3
        apb_xfer("rd80", 1'b0, 8'h80, 32'h0, 0, 32'h0, 1'b0, 0, 32'h0,
                 lat, slverr, rdata, saw_req, a_wr, a_addr, a_wdata);
        chk("rd80_lat", lat, 32'd3);
        chk("rd80_err", {31'd0, slverr}, 32'd1);
        chk("rd80_data", rdata, 32'd0);
        chk("rd80_req", {31'd0, saw_req}, 32'd0);

        // Timeout: no ack ever -> cycle TIMEOUT+2 = 18
        apb_xfer("tmo14", 1'b0, 8'h14, 32'h0, 0, 32'h0, 1'b0, 0, 32'h0,
                 lat, slverr, rdata, saw_req, a_wr, a_addr, a_wdata);
        chk("tmo_lat", lat, 32'd18);
        chk("tmo_err", {31'd0, slverr}, 32'd1);
        chk("tmo_data", rdata, 32'd0);
        chk("tmo_req", {31'd0, saw_req}, 32'd1);
        tick();
        chk("tmo_idle", {31'd0, busy}, 32'd0);
        bk_ack = 1'b1; bk_rdata = 32'h7777_7777;
        late_ready = 1'b0;
        tick();
        bk_ack = 1'b0;
        if (PREADY) late_ready = 1'b1;
        tick();
        if (PREADY) late_ready = 1'b1;
        chk("late_ack_ready", {31'd0, late_ready}, 32'd0);
        chk("late_ack_busy", {31'd0, busy}, 32'd0);
        chk("late_ack_data", PRDATA, 32'd0);

        // PSEL dropped during the ACCESS wait
        wait_cfg = 4'd4;
        tick();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h18;
        tick();
        PENABLE = 1'b1;
        tick();
        chk("drop_req_c2", {31'd0, bk_req}, 32'd1);
        tick();
        chk("drop_req_c3", {31'd0, bk_req}, 32'd1);
        PSEL = 1'b0; PENABLE = 1'b0;
        tick();
        chk("drop_prot", {31'd0, prot_err}, 32'd1);
        chk("drop_req", {31'd0, bk_req}, 32'd0);
        chk("drop_ready", {31'd0, PREADY}, 32'd0);
        chk("drop_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("drop_prot_clr", {31'd0, prot_err}, 32'd0);
        $display("xfer drop addr=18 aborted in ACCESS");
        wait_cfg = 4'd0;
        apb_xfer("rd1c", 1'b0, 8'h1C, 32'h0, 2, 32'h0000_1C1C, 1'b0, 0, 32'h0,
                 lat, slverr, rdata, saw_req, a_wr, a_addr, a_wdata);
        chk("rd1c_lat", lat, 32'd3);
        chk("rd1c_data", rdata, 32'h0000_1C1C);

        // PSEL dropped in SETUP
        tick();
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 8'h20;
        tick();
        PSEL = 1'b0;
        tick();
        chk("setup_drop_prot", {31'd0, prot_err}, 32'd1);
        chk("setup_drop_busy", {31'd0, busy}, 32'd0);
        $display("xfer drop addr=20 aborted in SETUP");

        // Back-to-back reads, reset during ACCESS of the second
        apb_xfer("b2b_a", 1'b0, 8'h24, 32'h0, 2, 32'hB2B0_0001, 1'b0, 0, 32'h0,
                 lat, slverr, rdata, saw_req, a_wr, a_addr, a_wdata);
        chk("b2b_a_lat", lat, 32'd3);
        chk("b2b_a_data", rdata, 32'hB2B0_0001);
        wait_cfg = 4'd6;
        tick();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h28; PWDATA = 32'hCAFE_0028;
        tick();
        PENABLE = 1'b1;
        tick();
        chk("b2b_b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_b_req", {31'd0, bk_req}, 32'd1);
        PRESETn = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, bk_req}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, PREADY}, 32'd0);
        chk("mid_rst_prdata", PRDATA, 32'd0);
        chk("mid_rst_bkwr", {31'd0, bk_wr}, 32'd0);
        chk("mid_rst_bkaddr", {24'd0, bk_addr}, 32'd0);
        chk("mid_rst_bkwdata", bk_wdata, 32'd0);
        $display("xfer b2b_b wr=1 addr=28 reset in ACCESS");
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        wait_cfg = 4'd0;
        tick();
        tick();
        PRESETn = 1'b1;
        apb_xfer("post_rst", 1'b0, 8'h2C, 32'h0, 2, 32'h0000_2C2C, 1'b0, 0, 32'h0,
                 lat, slverr, rdata, saw_req, a_wr, a_addr, a_wdata);
        chk("post_rst_lat", lat, 32'd3);
        chk("post_rst_err", {31'd0, slverr}, 32'd0);
        chk("post_rst_data", rdata, 32'h0000_2C2C);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_apb_slave_ctrl
